hazard_unit_p: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage dual-write-port pipelined CPU (F, D, E, M, W). Replaces the fixed 8-register hazard unit.
- Generalised register-file depth and load latency.
- Adds a multi-cycle execute unit interlock (busy counter) and a saturating stall-cycle performance counter.
- Sits beside the datapath. Drives the forwarding muxes in E and the stall/flush enables of the F/D/E pipeline registers.

---
 rtl/hazard_unit_p.sv | 197 +++++++++++++++++++
 tb/tb_hazard_unit_p.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_p.sv
// -----------------------------------------------------------------------------
// hazard_unit_p
// Hazard detection and forwarding control for a 5-stage (F, D, E, M, W)
// pipeline whose register file has two write ports.
//
// Forwarding (E stage, combinational):
//   ForwardAE / ForwardBE : 0 = register file, 1 = W port1, 2 = W port2,
//                           3 = M port1,       4 = M port2.
//   M beats W; inside one stage port2 beats port1. Every address forwards,
//   including register 0.
//
// Pipeline control (combinational from inputs and counter state):
//   StallF, StallD, StallE : hold the F/D/E pipeline registers
//   FlushD, FlushE         : turn the D/E pipeline registers into bubbles
//   McBusy                 : a multi-cycle op is still occupying E
//   StallCount             : saturating count of cycles with StallF = 1
//
// Inputs:
//   clk, reset (async, active-low)
//   Ra1D/Ra2D, Ra1E/Ra2E   : source registers in D and E
//   Wa1E, LoadE            : destination and load flag of the E instruction
//   McStartE               : one-cycle pulse when a multi-cycle op enters E
//   PCSrcE                 : taken branch resolved in E
//   Wa1M/Wa2M, RegWrite1M/RegWrite2M : M-stage write ports
//   Wa1W/Wa2W, RegWrite1W/RegWrite2W : W-stage write ports
//
// Precedence of the control decisions: reset, McBusy, PCSrcE, load-use.
// -----------------------------------------------------------------------------
module hazard_unit_p #(
  parameter int REG_AW   = 3,
  parameter int LOAD_LAT = 1,
  parameter int MC_LAT   = 4,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Ra1D,
  input  logic [REG_AW-1:0] Ra2D,
  input  logic [REG_AW-1:0] Ra1E,
  input  logic [REG_AW-1:0] Ra2E,
  input  logic [REG_AW-1:0] Wa1E,
  input  logic              LoadE,
  input  logic              McStartE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] Wa1M,
  input  logic [REG_AW-1:0] Wa2M,
  input  logic              RegWrite1M,
  input  logic              RegWrite2M,
  input  logic [REG_AW-1:0] Wa1W,
  input  logic [REG_AW-1:0] Wa2W,
  input  logic              RegWrite1W,
  input  logic              RegWrite2W,
  output logic [2:0]        ForwardAE,
  output logic [2:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              McBusy,
  output logic [PERF_W-1:0] StallCount
);

  localparam logic [2:0] FWD_RF = 3'd0;
  localparam logic [2:0] FWD_W1 = 3'd1;
  localparam logic [2:0] FWD_W2 = 3'd2;
  localparam logic [2:0] FWD_M1 = 3'd3;
  localparam logic [2:0] FWD_M2 = 3'd4;

  // Counter reload values: the cycle that detects the hazard/op is the first
  // stall cycle, so the counter only covers the remaining ones.
  localparam logic [2:0] LD_RELOAD = 3'(LOAD_LAT - 1);
  localparam logic [3:0] MC_RELOAD = 4'(MC_LAT - 1);
  localparam logic [PERF_W-1:0] CNT_MAX = {PERF_W{1'b1}};

  logic [2:0]        r_ld_cnt;
  logic [3:0]        r_mc_cnt;
  logic [PERF_W-1:0] r_stall_cnt;

  logic [2:0]        w_ld_nxt;
  logic [3:0]        w_mc_nxt;
  logic              w_busy;
  logic              w_hit;
  logic [2:0]        w_fwd_a;
  logic [2:0]        w_fwd_b;

  // Priority forward select for one E-stage source register.
  function automatic logic [2:0] fwd_sel(
    input logic [REG_AW-1:0] ra,
    input logic              we1m,
    input logic [REG_AW-1:0] wa1m,
    input logic              we2m,
    input logic [REG_AW-1:0] wa2m,
    input logic              we1w,
    input logic [REG_AW-1:0] wa1w,
    input logic              we2w,
    input logic [REG_AW-1:0] wa2w
  );
    logic [2:0] sel;
    if (we2m && (wa2m == ra)) begin
      sel = FWD_M2;
    end else if (we1m && (wa1m == ra)) begin
      sel = FWD_M1;
    end else if (we2w && (wa2w == ra)) begin
      sel = FWD_W2;
    end else if (we1w && (wa1w == ra)) begin
      sel = FWD_W1;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Forward selects for both E-stage sources.
  always_comb begin
    w_fwd_a = fwd_sel(Ra1E, RegWrite1M, Wa1M, RegWrite2M, Wa2M,
                      RegWrite1W, Wa1W, RegWrite2W, Wa2W);
    w_fwd_b = fwd_sel(Ra2E, RegWrite1M, Wa1M, RegWrite2M, Wa2M,
                      RegWrite1W, Wa1W, RegWrite2W, Wa2W);
  end

  // Stall/flush decisions and next counter values, highest priority first.
  always_comb begin
    w_busy    = (r_mc_cnt != 4'd0);
    w_hit     = LoadE && ((Wa1E == Ra1D) || (Wa1E == Ra2D));
    ForwardAE = w_fwd_a;
    ForwardBE = w_fwd_b;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    McBusy    = w_busy;
    w_ld_nxt  = r_ld_cnt;
    w_mc_nxt  = r_mc_cnt;
    if (!reset) begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      McBusy    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      w_ld_nxt  = 3'd0;
      w_mc_nxt  = 4'd0;
    end else if (w_busy) begin
      // E holds the multi-cycle op: branch and load-use wait (ld_cnt frozen).
      StallF   = 1'b1;
      StallD   = 1'b1;
      StallE   = 1'b1;
      w_mc_nxt = r_mc_cnt - 4'd1;
    end else if (PCSrcE) begin
      // Taken branch squashes D and E, including any pending load stall
      // and any multi-cycle op that was about to start.
      FlushD   = 1'b1;
      FlushE   = 1'b1;
      w_ld_nxt = 3'd0;
    end else begin
      if (McStartE) begin
        w_mc_nxt = MC_RELOAD;
      end else begin
        w_mc_nxt = r_mc_cnt;
      end
      if (r_ld_cnt != 3'd0) begin
        StallF   = 1'b1;
        StallD   = 1'b1;
        FlushE   = 1'b1;
        w_ld_nxt = r_ld_cnt - 3'd1;
      end else if (w_hit) begin
        StallF   = 1'b1;
        StallD   = 1'b1;
        FlushE   = 1'b1;
        w_ld_nxt = LD_RELOAD;
      end else begin
        w_ld_nxt = r_ld_cnt;
      end
    end
  end

  // Counter state and saturating stall-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_cnt    <= 3'd0;
      r_mc_cnt    <= 4'd0;
      r_stall_cnt <= '0;
    end else begin
      r_ld_cnt <= w_ld_nxt;
      r_mc_cnt <= w_mc_nxt;
      if (StallF && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit_p.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit_p
// Directed scenarios plus randomized traffic for hazard_unit_p, checked
// against a cycle-level reference model of the hazard rules.
// DUT configuration: REG_AW=3, LOAD_LAT=3, MC_LAT=4, PERF_W=4.
// -----------------------------------------------------------------------------
module tb_hazard_unit_p;

  localparam int REG_AW   = 3;
  localparam int LOAD_LAT = 3;
  localparam int MC_LAT   = 4;
  localparam int PERF_W   = 4;
  localparam int CNT_MAX  = (1 << PERF_W) - 1;

  logic              clk;
  logic              reset;
  logic [REG_AW-1:0] Ra1D, Ra2D, Ra1E, Ra2E, Wa1E;
  logic              LoadE, McStartE, PCSrcE;
  logic [REG_AW-1:0] Wa1M, Wa2M, Wa1W, Wa2W;
  logic              RegWrite1M, RegWrite2M, RegWrite1W, RegWrite2W;
  logic [2:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE, FlushD, FlushE, McBusy;
  logic [PERF_W-1:0] StallCount;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: remaining extra load stall cycles, remaining busy
  // cycles of a multi-cycle op, and the stall-cycle count.
  int m_ld  = 0;
  int m_mc  = 0;
  int m_cnt = 0;

  // Last observed outputs, for directed scenario bookkeeping.
  logic [2:0] last_fa, last_fb;
  logic       last_sf, last_se, last_busy, last_fd, last_fe;

  hazard_unit_p #(
    .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .MC_LAT(MC_LAT), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .reset(reset),
    .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E), .Wa1E(Wa1E),
    .LoadE(LoadE), .McStartE(McStartE), .PCSrcE(PCSrcE),
    .Wa1M(Wa1M), .Wa2M(Wa2M), .RegWrite1M(RegWrite1M), .RegWrite2M(RegWrite2M),
    .Wa1W(Wa1W), .Wa2W(Wa2W), .RegWrite1W(RegWrite1W), .RegWrite2W(RegWrite2W),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .McBusy(McBusy), .StallCount(StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Forward source for one register: scan the write ports from most recent
  // (M port2) to oldest (W port1) and take the first enabled match.
  function automatic int exp_fwd(input int ra);
    int en [4];
    int wa [4];
    int code [4];
    en[0] = RegWrite2M; wa[0] = Wa2M; code[0] = 4;
    en[1] = RegWrite1M; wa[1] = Wa1M; code[1] = 3;
    en[2] = RegWrite2W; wa[2] = Wa2W; code[2] = 2;
    en[3] = RegWrite1W; wa[3] = Wa1W; code[3] = 1;
    for (int k = 0; k < 4; k++) begin
      if (en[k] != 0 && wa[k] == ra) return code[k];
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_ld  = 0;
    m_mc  = 0;
    m_cnt = 0;
  endtask

  // One clock cycle: inputs already applied; check outputs mid-cycle against
  // the model, then advance the model across the rising edge.
  task automatic cycle();
    bit busy, hit, stall_fd, e_se, e_fd, e_fe;
    #2;
    busy = (m_mc > 0);
    hit  = LoadE && ((Wa1E == Ra1D) || (Wa1E == Ra2D));
    stall_fd = 1'b0; e_se = 1'b0; e_fd = 1'b0; e_fe = 1'b0;
    if (busy) begin
      stall_fd = 1'b1; e_se = 1'b1;
    end else if (PCSrcE) begin
      e_fd = 1'b1; e_fe = 1'b1;
    end else if (m_ld > 0 || hit) begin
      stall_fd = 1'b1; e_fe = 1'b1;
    end
    check("fwdA",   32'(ForwardAE),  32'(exp_fwd(int'(Ra1E))));
    check("fwdB",   32'(ForwardBE),  32'(exp_fwd(int'(Ra2E))));
    check("stallF", 32'(StallF),     32'(stall_fd));
    check("stallD", 32'(StallD),     32'(stall_fd));
    check("stallE", 32'(StallE),     32'(e_se));
    check("flushD", 32'(FlushD),     32'(e_fd));
    check("flushE", 32'(FlushE),     32'(e_fe));
    check("busy",   32'(McBusy),     32'(busy));
    check("count",  32'(StallCount), 32'(m_cnt));
    last_fa = ForwardAE; last_fb = ForwardBE; last_sf = StallF;
    last_se = StallE; last_busy = McBusy; last_fd = FlushD; last_fe = FlushE;
    @(posedge clk);
    #1;
    if (busy) begin
      m_mc = m_mc - 1;
    end else begin
      if (PCSrcE) m_ld = 0;
      else if (m_ld > 0) m_ld = m_ld - 1;
      else if (hit) m_ld = LOAD_LAT - 1;
      if (McStartE && !PCSrcE) m_mc = MC_LAT - 1;
    end
    if (stall_fd) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
  endtask

  task automatic clear_inputs();
    Ra1D = '0; Ra2D = '0; Ra1E = '0; Ra2E = '0; Wa1E = '0;
    LoadE = 1'b0; McStartE = 1'b0; PCSrcE = 1'b0;
    Wa1M = '0; Wa2M = '0; Wa1W = '0; Wa2W = '0;
    RegWrite1M = 1'b0; RegWrite2M = 1'b0; RegWrite1W = 1'b0; RegWrite2W = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fwdA"},  32'(ForwardAE),  32'd0);
    check({tag, "_fwdB"},  32'(ForwardBE),  32'd0);
    check({tag, "_stallF"}, 32'(StallF),    32'd0);
    check({tag, "_stallE"}, 32'(StallE),    32'd0);
    check({tag, "_busy"},  32'(McBusy),     32'd0);
    check({tag, "_flushD"}, 32'(FlushD),    32'd1);
    check({tag, "_flushE"}, 32'(FlushE),    32'd1);
    check({tag, "_count"}, 32'(StallCount), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic randomize_inputs();
    Ra1D = REG_AW'($urandom_range(0, 3)); Ra2D = REG_AW'($urandom_range(0, 3));
    Ra1E = REG_AW'($urandom_range(0, 3)); Ra2E = REG_AW'($urandom_range(0, 3));
    Wa1E = REG_AW'($urandom_range(0, 3));
    Wa1M = REG_AW'($urandom_range(0, 3)); Wa2M = REG_AW'($urandom_range(0, 3));
    Wa1W = REG_AW'($urandom_range(0, 3)); Wa2W = REG_AW'($urandom_range(0, 3));
    RegWrite1M = 1'($urandom_range(0, 1)); RegWrite2M = 1'($urandom_range(0, 1));
    RegWrite1W = 1'($urandom_range(0, 1)); RegWrite2W = 1'($urandom_range(0, 1));
    LoadE  = ($urandom_range(0, 3) == 0);
    PCSrcE = ($urandom_range(0, 7) == 0);
    // A multi-cycle op only enters an idle E stage that holds no load.
    McStartE = (m_mc == 0) && (m_ld == 0) && !LoadE && ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    int cnt;
    clear_inputs();
    reset = 1'b0;
    // Reset state, with forwarding inputs that would otherwise match.
    RegWrite1M = 1'b1; Wa1M = 3'd5; Ra1E = 3'd5; Ra2E = 3'd5;
    #12;
    check_reset_outputs("rst");
    clear_inputs();
    release_reset();

    // Load-use with LOAD_LAT=3: exactly 3 stall cycles, count rises by 3.
    cnt = 0;
    Wa1E = 3'd4; Ra2D = 3'd4; Ra1D = 3'd1;
    for (int i = 0; i < 5; i++) begin
      LoadE = (i < LOAD_LAT);
      cycle();
      if (last_sf) cnt++;
    end
    check("lduse_len", 32'(cnt), 32'd3);
    #2;
    check("lduse_count", 32'(StallCount), 32'd3);
    clear_inputs();

    // Dual-port forward: M port1 beats W port2, then W port2 alone.
    RegWrite1M = 1'b1; Wa1M = 3'd5; RegWrite2W = 1'b1; Wa2W = 3'd5;
    Ra1E = 3'd5; Ra2E = 3'd5;
    cycle();
    check("dual_M_A", 32'(last_fa), 32'd3);
    check("dual_M_B", 32'(last_fb), 32'd3);
    RegWrite1M = 1'b0;
    cycle();
    check("dual_W_A", 32'(last_fa), 32'd2);
    check("dual_W_B", 32'(last_fb), 32'd2);
    clear_inputs();

    // Same-stage conflict: port2 wins.
    RegWrite1M = 1'b1; RegWrite2M = 1'b1; Wa1M = 3'd2; Wa2M = 3'd2; Ra1E = 3'd2;
    cycle();
    check("same_stage", 32'(last_fa), 32'd4);
    clear_inputs();

    // Multi-cycle op: 3 busy cycles, branch during busy has no effect.
    McStartE = 1'b1;
    cycle();
    McStartE = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      PCSrcE = (i == 1);
      cycle();
      if (last_busy) cnt++;
      if (i == 1) check("mc_branch_flushD", 32'(last_fd), 32'd0);
    end
    check("mc_busy_len", 32'(cnt), 32'd3);
    clear_inputs();

    // Branch together with a load-use hit: branch wins, no stall afterwards.
    LoadE = 1'b1; Wa1E = 3'd4; Ra2D = 3'd4; PCSrcE = 1'b1;
    cycle();
    check("br_ld_stallF", 32'(last_sf), 32'd0);
    check("br_ld_flushE", 32'(last_fe), 32'd1);
    clear_inputs();
    cycle();
    check("br_ld_after", 32'(last_sf), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      cycle();
    end
    clear_inputs();
    for (int i = 0; i < 4; i++) cycle();

    // Saturation: a held hit keeps stalling until the counter pins at 15.
    LoadE = 1'b1; Wa1E = 3'd6; Ra1D = 3'd6;
    for (int i = 0; i < 20; i++) cycle();
    #2;
    check("saturate", 32'(StallCount), 32'd15);
    clear_inputs();
    cycle();

    // Async reset in the middle of a multi-cycle op, between clock edges.
    McStartE = 1'b1;
    cycle();
    McStartE = 1'b0;
    RegWrite2M = 1'b1; Wa2M = 3'd3; Ra1E = 3'd3; Ra2E = 3'd3;
    cycle();
    check("pre_rst_busy", 32'(last_busy), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    clear_inputs();
    release_reset();
    for (int i = 0; i < 3; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
